// File: rtl/gray_pkg.sv
// Width-generic binary/Gray conversion helpers shared by the counter and standalone converters.
// Operands are carried in 32 bits; bits at or above the width argument are ignored.
package gray_pkg;

    function automatic logic [31:0] width_mask(input int unsigned width);
        if (width >= 32) begin
            return '1;
        end
        return (32'd1 << width) - 32'd1;
    endfunction

    function automatic logic [31:0] bin2gray(input logic [31:0] bin, input int unsigned width);
        logic [31:0] b;
        b = bin & width_mask(width);
        return b ^ (b >> 1);
    endfunction

    // Upper bits are zeroed first, so the prefix-XOR runs uniformly over all 32 bits.
    function automatic logic [31:0] gray2bin(input logic [31:0] gray, input int unsigned width);
        logic [31:0] g;
        logic [31:0] b;
        g = gray & width_mask(width);
        b = '0;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Combinational Gray-to-binary converter used on the counter load path.
module gray_to_bin
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    logic [31:0] bin_wide;

    always_comb begin
        bin_wide = gray2bin(32'(gray), WIDTH);
        bin      = bin_wide[WIDTH-1:0];
    end

endmodule

// File: rtl/gray_code_counter.sv
// Up/down binary counter with registered Gray-code output and a registered wrap pulse.
// Gray is computed from the next count so gray_out comes straight from a flop.
module gray_code_counter
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned RST_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic             load_gray,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] bin_out,
    output logic [WIDTH-1:0] gray_out,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] RstBin = WIDTH'(RST_VAL);
    localparam logic [31:0] RstGrayWide = bin2gray(32'(RstBin), WIDTH);
    localparam logic [WIDTH-1:0] RstGray = RstGrayWide[WIDTH-1:0];

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] load_bin;
    logic [31:0]      gray_wide;

    gray_to_bin #(
        .WIDTH(WIDTH)
    ) u_load_conv (
        .gray(load_val),
        .bin (load_bin)
    );

    // Priority: load > en > hold; a load never produces a wrap pulse.
    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        if (load) begin
            cnt_d = load_gray ? load_bin : load_val;
        end else if (en) begin
            if (up) begin
                cnt_d  = cnt_q + 1'b1;
                wrap_d = (cnt_q == '1);
            end else begin
                cnt_d  = cnt_q - 1'b1;
                wrap_d = (cnt_q == '0);
            end
        end
        gray_wide = bin2gray(32'(cnt_d), WIDTH);
        gray_d    = gray_wide[WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= RstBin;
            gray_q <= RstGray;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            gray_q <= gray_d;
            wrap_q <= wrap_d;
        end
    end

    assign bin_out  = cnt_q;
    assign gray_out = gray_q;
    assign wrap     = wrap_q;

endmodule

// File: tb/tb_gray_code_counter.sv
// Directed checks on a 3-bit counter plus a long randomised run on an 8-bit counter.
module tb_gray_code_counter;

    logic       clk = 1'b0;
    logic       rst, en, up, load, load_gray;
    logic [2:0] load_val, bin_out, gray_out;
    logic       wrap;

    logic       rst8, en8, up8, load8, load_gray8;
    logic [7:0] load_val8, bin_out8, gray_out8;
    logic       wrap8;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    gray_code_counter #(.WIDTH(3), .RST_VAL(0)) dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_gray(load_gray),
        .load_val(load_val), .bin_out(bin_out), .gray_out(gray_out), .wrap(wrap)
    );

    gray_code_counter #(.WIDTH(8), .RST_VAL(5)) dut8 (
        .clk(clk), .rst(rst8), .en(en8), .up(up8), .load(load8), .load_gray(load_gray8),
        .load_val(load_val8), .bin_out(bin_out8), .gray_out(gray_out8), .wrap(wrap8)
    );

    function automatic logic [7:0] b2g8(input logic [7:0] b);
        return b ^ {1'b0, b[7:1]};
    endfunction

    function automatic logic [7:0] g2b8(input logic [7:0] g);
        logic [7:0] b;
        b[7] = g[7];
        for (int i = 6; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; load_gray = 1'b0; load_val = 3'b000;
        #2 rst = 1'b1;
        #1;
        total++;
        if ({bin_out, gray_out, wrap} !== 7'b000_000_0) begin
            bad++;
            $display("FAIL reset_initial: got bin=%b gray=%b wrap=%b want 000 000 0",
                     bin_out, gray_out, wrap);
        end
        tick();
        rst = 1'b0;
        en = 1'b1; up = 1'b0;
        tick();
        total++;
        if ({bin_out, gray_out, wrap} !== 7'b111_100_1) begin
            bad++;
            $display("FAIL pre_reset_wrap: got bin=%b gray=%b wrap=%b want 111 100 1",
                     bin_out, gray_out, wrap);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if ({bin_out, gray_out, wrap} !== 7'b000_000_0) begin
            bad++;
            $display("FAIL reset_async: got bin=%b gray=%b wrap=%b want 000 000 0",
                     bin_out, gray_out, wrap);
        end
        load = 1'b1; load_val = 3'b101; up = 1'b1;
        tick();
        total++;
        if ({bin_out, gray_out, wrap} !== 7'b000_000_0) begin
            bad++;
            $display("FAIL reset_ignores_inputs: got bin=%b gray=%b wrap=%b want 000 000 0",
                     bin_out, gray_out, wrap);
        end
        load = 1'b0; en = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_count_up();
        logic [2:0] exp_gray [8];
        exp_gray = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
        en = 1'b1; up = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            total++;
            if (bin_out !== 3'(i + 1) || gray_out !== exp_gray[i] || wrap !== (i == 7)) begin
                bad++;
                $display("FAIL count_up[%0d]: got bin=%b gray=%b wrap=%b want %b %b %b", i,
                         bin_out, gray_out, wrap, 3'(i + 1), exp_gray[i], (i == 7));
            end
        end
        en = 1'b0;
    endtask

    task automatic test_count_down();
        en = 1'b1; up = 1'b0;
        tick();
        total++;
        if ({bin_out, gray_out, wrap} !== 7'b111_100_1) begin
            bad++;
            $display("FAIL down_wrap: got bin=%b gray=%b wrap=%b want 111 100 1",
                     bin_out, gray_out, wrap);
        end
        en = 1'b0;
        tick();
        total++;
        if ({bin_out, gray_out, wrap} !== 7'b111_100_0) begin
            bad++;
            $display("FAIL hold: got bin=%b gray=%b wrap=%b want 111 100 0",
                     bin_out, gray_out, wrap);
        end
    endtask

    task automatic test_load();
        load = 1'b1; load_gray = 1'b1; load_val = 3'b101; en = 1'b1; up = 1'b1;
        tick();
        total++;
        if ({bin_out, gray_out, wrap} !== 7'b110_101_0) begin
            bad++;
            $display("FAIL load_gray: got bin=%b gray=%b wrap=%b want 110 101 0",
                     bin_out, gray_out, wrap);
        end
        load_gray = 1'b0; load_val = 3'b000;
        tick();
        load_val = 3'b111;
        tick();
        total++;
        if ({bin_out, gray_out, wrap} !== 7'b111_100_0) begin
            bad++;
            $display("FAIL load_bin_no_wrap: got bin=%b gray=%b wrap=%b want 111 100 0",
                     bin_out, gray_out, wrap);
        end
        load_val = 3'b000;
        tick();
        total++;
        if ({bin_out, gray_out, wrap} !== 7'b000_000_0) begin
            bad++;
            $display("FAIL load_zero_no_wrap: got bin=%b gray=%b wrap=%b want 000 000 0",
                     bin_out, gray_out, wrap);
        end
        load = 1'b0; en = 1'b0;
    endtask

    task automatic test_direction();
        logic       dir [4];
        logic [2:0] exp_bin [4];
        logic [2:0] exp_gray [4];
        logic       exp_wrap [4];
        dir      = '{1'b1, 1'b0, 1'b0, 1'b1};
        exp_bin  = '{3'b001, 3'b000, 3'b111, 3'b000};
        exp_gray = '{3'b001, 3'b000, 3'b100, 3'b000};
        exp_wrap = '{1'b0, 1'b0, 1'b1, 1'b1};
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            up = dir[i];
            tick();
            total++;
            if (bin_out !== exp_bin[i] || gray_out !== exp_gray[i] || wrap !== exp_wrap[i]) begin
                bad++;
                $display("FAIL direction[%0d]: got bin=%b gray=%b wrap=%b want %b %b %b", i,
                         bin_out, gray_out, wrap, exp_bin[i], exp_gray[i], exp_wrap[i]);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_mid_reset();
        load = 1'b1; load_gray = 1'b0; load_val = 3'b110;
        tick();
        load = 1'b0; en = 1'b1; up = 1'b1;
        #2 rst = 1'b1;
        #1;
        total++;
        if ({bin_out, gray_out, wrap} !== 7'b000_000_0) begin
            bad++;
            $display("FAIL mid_reset: got bin=%b gray=%b wrap=%b want 000 000 0",
                     bin_out, gray_out, wrap);
        end
        tick();
        #3 rst = 1'b0;
        tick();
        total++;
        if ({bin_out, gray_out, wrap} !== 7'b001_001_0) begin
            bad++;
            $display("FAIL resume: got bin=%b gray=%b wrap=%b want 001 001 0",
                     bin_out, gray_out, wrap);
        end
        en = 1'b0;
    endtask

    task automatic test_random8();
        logic [7:0] exp_bin, prev_gray, nxt;
        logic       exp_wrap, stepped;
        rst8 = 1'b0; en8 = 1'b0; up8 = 1'b0; load8 = 1'b0; load_gray8 = 1'b0; load_val8 = '0;
        #2 rst8 = 1'b1;
        #1;
        total++;
        if (bin_out8 !== 8'd5 || gray_out8 !== 8'd7 || wrap8 !== 1'b0) begin
            bad++;
            $display("FAIL reset8: got bin=%h gray=%h wrap=%b want 05 07 0",
                     bin_out8, gray_out8, wrap8);
        end
        #3 rst8 = 1'b0;
        exp_bin = 8'd5;
        for (int c = 0; c < 10000; c++) begin
            en8        = ($urandom_range(0, 3) != 0);
            up8        = 1'($urandom_range(0, 1));
            load8      = ($urandom_range(0, 15) == 0);
            load_gray8 = 1'($urandom_range(0, 1));
            load_val8  = (c % 97 == 0) ? 8'hff : 8'($urandom);
            // Steer towards the wrap points regularly.
            if (c % 50 == 0) begin
                load8 = 1'b1; load_gray8 = 1'b0; load_val8 = up8 ? 8'hfd : 8'h02;
            end
            exp_wrap = 1'b0;
            stepped  = 1'b0;
            if (load8) begin
                nxt = load_gray8 ? g2b8(load_val8) : load_val8;
            end else if (en8) begin
                stepped  = 1'b1;
                exp_wrap = up8 ? (exp_bin == 8'hff) : (exp_bin == 8'h00);
                nxt      = up8 ? exp_bin + 8'd1 : exp_bin - 8'd1;
            end else begin
                nxt = exp_bin;
            end
            prev_gray = gray_out8;
            tick();
            exp_bin = nxt;
            total++;
            if (bin_out8 !== exp_bin || gray_out8 !== b2g8(exp_bin) || wrap8 !== exp_wrap) begin
                bad++;
                $display("FAIL random8[%0d]: got bin=%h gray=%h wrap=%b want %h %h %b", c,
                         bin_out8, gray_out8, wrap8, exp_bin, b2g8(exp_bin), exp_wrap);
            end
            if (stepped) begin
                total++;
                if ($countones(gray_out8 ^ prev_gray) != 1) begin
                    bad++;
                    $display("FAIL hamming8[%0d]: got gray %h -> %h want one bit change", c,
                             prev_gray, gray_out8);
                end
            end
        end
    endtask

    initial begin
        rst8 = 1'b0; en8 = 1'b0; up8 = 1'b0; load8 = 1'b0; load_gray8 = 1'b0; load_val8 = '0;
        test_reset();
        test_count_up();
        test_count_down();
        test_load();
        test_direction();
        test_mid_reset();
        test_random8();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
